cic_rate_ctrl: RTL and testbench

Rate-change sequencer for the variable-decimation CIC decimator in the receive chain. It synchronises the host speed request and applies it to the CIC's extra_decimation select without glitches. On every change, and after reset, it flushes the CIC and suppresses output-valid until the comb pipeline has settled. It sits between the host control register and the CIC instance, and gates that instance's input and output strobes.

---
 rtl/cic_rate_ctrl.sv | 137 +++++++++++++
 tb/tb_cic_rate_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cic_rate_ctrl.sv
// Rate-change sequencer for the variable-decimation CIC: syncs the host speed request,
// flushes the CIC on every change and qualifies its outputs. Optional watchdog: CIC_RATE_WATCHDOG_EN.
module cic_rate_ctrl #(
  parameter int         STAGES         = 5,
  parameter int         CLEAR_CYCLES   = 4,
  parameter int         SETTLE_OUTPUTS = STAGES + 1,
  parameter logic [1:0] RESET_RATE     = 2'b00,
  parameter int         WD_CYCLES      = 65535
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] speed_req,
  input  logic       in_strobe,
  output logic       cic_in_strobe,
  input  logic       cic_out_strobe,
  output logic       cic_clear,
  output logic [1:0] extra_decimation,
  output logic       data_valid,
  output logic       busy,
  output logic       rate_changed,
  output logic       wd_error
);

  localparam int CW = $clog2(CLEAR_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_OUTPUTS + 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_OUTPUTS - 1);

  if (CLEAR_CYCLES < 1) begin : g_bad_clear
    $error("CLEAR_CYCLES must be at least 1");
  end
  if (SETTLE_OUTPUTS < 1) begin : g_bad_settle
    $error("SETTLE_OUTPUTS must be at least 1");
  end
  if (WD_CYCLES < 1 || WD_CYCLES > 65535) begin : g_bad_wd
    $error("WD_CYCLES must fit the 16-bit watchdog");
  end

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    CLEAR  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    s1, s2, s3;
  logic          out_q;
  logic [CW-1:0] clr_cnt;
  logic [SW-1:0] set_cnt;
  logic          req_stable;
  logic          wd_expire;

  // 11 is never a legal rate, so it can never look stable and is simply ignored
  assign req_stable = (s2 == s3) && (s3 != 2'b11);

  assign cic_in_strobe = in_strobe & (state != CLEAR);
  assign cic_clear     = (state == CLEAR);
  assign busy          = (state != RUN);
  assign data_valid    = out_q & (state == RUN);

`ifdef CIC_RATE_WATCHDOG_EN
  localparam logic [15:0] WD_LAST = 16'(WD_CYCLES - 1);
  logic [15:0] wd_cnt;

  assign wd_expire = (state == SETTLE) && !cic_out_strobe && (wd_cnt == WD_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt   <= '0;
      wd_error <= 1'b0;
    end else begin
      wd_error <= wd_expire;
      if (state != SETTLE || cic_out_strobe)
        wd_cnt <= '0;
      else if (wd_cnt != WD_LAST)
        wd_cnt <= wd_cnt + 16'd1;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign wd_error  = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1               <= RESET_RATE;
      s2               <= RESET_RATE;
      s3               <= RESET_RATE;
      out_q            <= 1'b0;
      state            <= CLEAR;
      extra_decimation <= RESET_RATE;
      clr_cnt          <= '0;
      set_cnt          <= '0;
      rate_changed     <= 1'b0;
    end else begin
      s1           <= speed_req;
      s2           <= s1;
      s3           <= s2;
      out_q        <= cic_out_strobe;
      rate_changed <= 1'b0;
      // a new stable rate wins over any flush in progress (last writer wins)
      if (req_stable && (s3 != extra_decimation)) begin
        extra_decimation <= s3;
        state            <= CLEAR;
        clr_cnt          <= '0;
        set_cnt          <= '0;
      end else begin
        case (state)
          CLEAR: begin
            if (clr_cnt == CLR_LAST) begin
              state   <= SETTLE;
              set_cnt <= '0;
            end else begin
              clr_cnt <= clr_cnt + 1'b1;
            end
          end
          SETTLE: begin
            if (wd_expire) begin
              state   <= CLEAR;
              clr_cnt <= '0;
              set_cnt <= '0;
            end else if (out_q) begin
              if (set_cnt == SET_LAST) begin
                state        <= RUN;
                rate_changed <= 1'b1;
              end else begin
                set_cnt <= set_cnt + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Self-checking bench for cic_rate_ctrl; the bench plays the CIC by driving cic_out_strobe.
module tb_cic_rate_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] speed_req;
  logic       in_strobe;
  logic       cic_in_strobe;
  logic       cic_out_strobe;
  logic       cic_clear;
  logic [1:0] extra_decimation;
  logic       data_valid;
  logic       busy;
  logic       rate_changed;
  logic       wd_error;

  cic_rate_ctrl dut (
    .clock            (clock),
    .reset            (reset),
    .speed_req        (speed_req),
    .in_strobe        (in_strobe),
    .cic_in_strobe    (cic_in_strobe),
    .cic_out_strobe   (cic_out_strobe),
    .cic_clear        (cic_clear),
    .extra_decimation (extra_decimation),
    .data_valid       (data_valid),
    .busy             (busy),
    .rate_changed     (rate_changed),
    .wd_error         (wd_error)
  );

  always #5 clock = ~clock;

  int n_pass   = 0;
  int n_total  = 0;
  int rc_count = 0;
  bit dv_q[$];

  typedef struct {
    logic [1:0] req;
    logic [1:0] exp_ed;
    bit         flush;
  } rate_vec_t;

  rate_vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Scoreboard consumer: each strobe the CIC produces is matched against the expected qualifier.
  bit seen;
  always @(posedge clock) begin
    seen = cic_out_strobe && !reset;
    #1;
    if (rate_changed) rc_count++;
    if (seen) begin
      check("sb_has_entry", 32'(dv_q.size() != 0), 32'd1);
      if (dv_q.size() != 0) check("data_valid", 32'(data_valid), 32'(dv_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse(input bit exp_dv, input int gap);
    dv_q.push_back(exp_dv);
    cic_out_strobe = 1'b1;
    tick();
    cic_out_strobe = 1'b0;
    repeat (gap) tick();
  endtask

  // Entered on the first CLEAR cycle; verifies the 4-clock flush with input strobes blocked.
  task automatic flush_check(input string tag, input logic [1:0] exp_ed);
    in_strobe = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check({tag, "_clear_hi"}, 32'(cic_clear), 32'd1);
      check({tag, "_in_blocked"}, 32'(cic_in_strobe), 32'd0);
      check({tag, "_ed"}, 32'(extra_decimation), 32'(exp_ed));
      tick();
    end
    check({tag, "_clear_lo"}, 32'(cic_clear), 32'd0);
    check({tag, "_in_pass"}, 32'(cic_in_strobe), 32'd1);
    in_strobe = 1'b0;
  endtask

  task automatic settle_and_run(input string tag);
    int rc0;
    for (int i = 0; i < 5; i++) pulse(1'b0, 6);
    check({tag, "_busy_settle"}, 32'(busy), 32'd1);
    rc0 = rc_count;
    pulse(1'b0, 6);
    check({tag, "_rate_changed"}, 32'(rc_count), 32'(rc0 + 1));
    check({tag, "_busy_run"}, 32'(busy), 32'd0);
    pulse(1'b1, 6);
    pulse(1'b1, 3);
  endtask

  initial begin
    int rc_base;
    vecs[0] = '{req: 2'b10, exp_ed: 2'b10, flush: 1'b1};
    vecs[1] = '{req: 2'b11, exp_ed: 2'b10, flush: 1'b0};
    vecs[2] = '{req: 2'b10, exp_ed: 2'b10, flush: 1'b0};
    vecs[3] = '{req: 2'b01, exp_ed: 2'b01, flush: 1'b1};
    vecs[4] = '{req: 2'b00, exp_ed: 2'b00, flush: 1'b1};

    reset = 1'b1;
    speed_req = 2'b00;
    in_strobe = 1'b0;
    cic_out_strobe = 1'b0;
    tick();
    tick();
    check("rst_clear", 32'(cic_clear), 32'd1);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ed", 32'(extra_decimation), 32'd0);
    check("rst_dv", 32'(data_valid), 32'd0);
    check("rst_rc", 32'(rate_changed), 32'd0);
    check("rst_wd", 32'(wd_error), 32'd0);
    in_strobe = 1'b1;
    #1;
    check("rst_in_blocked", 32'(cic_in_strobe), 32'd0);
    in_strobe = 1'b0;
    reset = 1'b0;
    flush_check("boot", 2'b00);
    settle_and_run("boot");

    for (int v = 0; v < 5; v++) begin
      speed_req = vecs[v].req;
      repeat (4) tick();
      if (vecs[v].flush) begin
        flush_check($sformatf("vec%0d", v), vecs[v].exp_ed);
        settle_and_run($sformatf("vec%0d", v));
      end else begin
        check($sformatf("vec%0d_no_clear", v), 32'(cic_clear), 32'd0);
        check($sformatf("vec%0d_no_busy", v), 32'(busy), 32'd0);
        repeat (4) tick();
        check($sformatf("vec%0d_busy_later", v), 32'(busy), 32'd0);
        check($sformatf("vec%0d_ed_kept", v), 32'(extra_decimation), 32'(vecs[v].exp_ed));
      end
    end

    // Change mid-SETTLE, then again early in the resulting CLEAR.
    speed_req = 2'b10;
    repeat (4) tick();
    rc_base = rc_count;
    flush_check("pre", 2'b10);
    for (int i = 0; i < 3; i++) pulse(1'b0, 6);
    speed_req = 2'b01;
    repeat (4) tick();
    check("abort_clear", 32'(cic_clear), 32'd1);
    check("abort_ed", 32'(extra_decimation), 32'd1);
    speed_req = 2'b10;
    repeat (3) tick();
    check("restart_pre_clear", 32'(cic_clear), 32'd1);
    check("restart_pre_ed", 32'(extra_decimation), 32'd1);
    tick();
    check("restart_clear", 32'(cic_clear), 32'd1);
    check("restart_ed", 32'(extra_decimation), 32'd2);
    repeat (3) tick();
    check("restart_len_hi", 32'(cic_clear), 32'd1);
    tick();
    check("restart_len_lo", 32'(cic_clear), 32'd0);
    settle_and_run("restart");
    check("restart_single_rc", 32'(rc_count), 32'(rc_base + 1));
    check("restart_final_ed", 32'(extra_decimation), 32'd2);

    // Reset pulse in the middle of a flush.
    speed_req = 2'b01;
    repeat (4) tick();
    check("mid_clear", 32'(cic_clear), 32'd1);
    tick();
    speed_req = 2'b00;
    reset = 1'b1;
    #1;
    check("async_ed", 32'(extra_decimation), 32'd0);
    check("async_clear", 32'(cic_clear), 32'd1);
    check("async_busy", 32'(busy), 32'd1);
    check("async_dv", 32'(data_valid), 32'd0);
    tick();
    reset = 1'b0;
    flush_check("rerst", 2'b00);
    settle_and_run("rerst");

    check("sb_drained", 32'(dv_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
